ifetch_queue: RTL and testbench

- Decoupled instruction-fetch front end for the 5-stage 64-bit pipeline; it replaces the combinational PC/IMEM path ahead of the IF/ID register.
- Issues in-order word fetches to an instruction-memory port using a valid/ready request and a fixed-order response.
- Buffers returned instructions, each with its PC, in a small FIFO that drains into IF/ID under the pipeline stall signal.
- Handles redirects (resolved branch or predicted-taken target) by flushing the buffer and discarding in-flight responses.

---
 rtl/cpu64_pkg.sv | 18 +
 rtl/ifetch_queue_if.sv | 28 ++
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/ifetch_queue.sv | 123 ++++++++++++
 tb/tb_ifetch_queue.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu64_pkg.sv
// Shared 64-bit pipeline definitions: widths, PC step and the fetch-buffer entry type.
package cpu64_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 64'd4;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Instruction fetch is word granular; low address bits are dropped.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_if.sv
// Bundle of redirect, instruction-memory and IF/ID-side signals of the fetch queue.
interface ifetch_queue_if;
  import cpu64_pkg::*;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_resp_valid;
  logic [INSTR_W-1:0] mem_resp_instr;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_pc;
  logic [XLEN-1:0]    out_pc_plus4;
  logic [INSTR_W-1:0] out_instr;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_instr, out_ready,
    output mem_req_valid, mem_req_addr, out_valid, out_pc, out_pc_plus4, out_instr
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_resp_valid, mem_resp_instr, out_ready,
    input  mem_req_valid, mem_req_addr, out_valid, out_pc, out_pc_plus4, out_instr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; pointers carry an extra wrap bit so count spans 0..DEPTH.
module fetch_fifo
  import cpu64_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t rdata,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  fetch_entry_t mem_q [DEPTH];

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointers; flush wins over any same-cycle push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop && !empty) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage; contents are only observed through a valid head, so no reset.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Decoupled fetch front end: credit-limited in-order requests, PC-tagged buffer, redirect discard.
module ifetch_queue
  import cpu64_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  ifetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + MAX_OUT + 1) + 1;
  localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
  localparam logic [CW-1:0] DEPTH_CW  = CW'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [OW-1:0]   disc_q, disc_d;
  logic            run_q;

  logic            req_valid_s, req_fire_s;
  logic            push_s, pop_s;
  logic [CW-1:0]   credit_s;
  logic [AW:0]     count_s;
  logic            full_s, empty_s;
  fetch_entry_t    head_s, wdata_s;

  // Slots already promised: buffered entries plus responses that will still be kept.
  assign credit_s = CW'(count_s) + CW'(outst_q) - CW'(disc_q);
  assign wdata_s  = '{pc: resp_pc_q, instr: bus.mem_resp_instr};

  // Request issue and buffer push/pop qualification.
  always_comb begin
    req_valid_s = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    if (run_q && !bus.redirect_valid && (outst_q < MAX_OUT_C) && (credit_s < DEPTH_CW)) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    if (bus.mem_resp_valid && (disc_q == '0) && !bus.redirect_valid) begin
      push_s = !full_s || (bus.out_ready && !empty_s);
    end else begin
      push_s = 1'b0;
    end
    pop_s = bus.out_ready && !empty_s && !bus.redirect_valid;
  end

  assign req_fire_s = req_valid_s && bus.mem_req_ready;

  // Next-state for PCs and the outstanding/discard counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + OW'(req_fire_s) - OW'(bus.mem_resp_valid);
    disc_d     = disc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = align_pc(bus.redirect_pc);
      resp_pc_d  = align_pc(bus.redirect_pc);
      disc_d     = outst_q - OW'(bus.mem_resp_valid);
    end else begin
      if (req_fire_s) begin
        fetch_pc_d = fetch_pc_q + PC_STEP;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + PC_STEP;
      end else begin
        resp_pc_d = resp_pc_q;
      end
      if (bus.mem_resp_valid && (disc_q != '0)) begin
        disc_d = disc_q - OW'(1);
      end else begin
        disc_d = disc_q;
      end
    end
  end

  // State registers; run_q holds off requests while reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      run_q      <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      run_q      <= 1'b1;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (wdata_s),
    .pop   (pop_s),
    .flush (bus.redirect_valid),
    .rdata (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  assign bus.mem_req_valid = req_valid_s;
  assign bus.mem_req_addr  = fetch_pc_q;
  assign bus.out_valid     = !empty_s;
  assign bus.out_pc        = empty_s ? '0 : head_s.pc;
  assign bus.out_pc_plus4  = empty_s ? '0 : head_s.pc + PC_STEP;
  assign bus.out_instr     = empty_s ? '0 : head_s.instr;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: fixed-latency memory model, expected entries queued at request.
module tb_ifetch_queue;
  import cpu64_pkg::*;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ifetch_queue_if bus();

  ifetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pend_t        pend_q[$];
  fetch_entry_t exp_q[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc, lat, n_req, n_out, first_req, first_out;
  logic         prev_redir, want_first;
  logic [63:0]  exp_fetch, first_target;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'hDEAD_0003;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    exp_fetch  = 64'h0;
    cyc        = 0;
    n_req      = 0;
    n_out      = 0;
    first_req  = -1;
    first_out  = -1;
    prev_redir = 1'b0;
    want_first = 1'b1;
    first_target = 64'h0;
  endtask

  task automatic drive_idle();
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 64'h0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_instr = 32'h0;
    bus.out_ready      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_valid"}, 64'(bus.mem_req_valid), 64'h0);
    check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
    check_eq({tag, "_out_pc"}, bus.out_pc, 64'h0);
    check_eq({tag, "_out_pc4"}, bus.out_pc_plus4, 64'h0);
    check_eq({tag, "_out_instr"}, 64'(bus.out_instr), 64'h0);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    drive_idle();
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later, update the model.
  task automatic step(input logic redir, input logic [63:0] rpc, input logic ordy);
    fetch_entry_t e;
    @(negedge clk);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_instr = mem_word(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_instr = 32'h0;
    end
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.out_ready      = ordy;
    bus.mem_req_ready  = 1'b1;
    #1;
    if (prev_redir) check_eq("valid_after_redirect", 64'(bus.out_valid), 64'h0);
    if (redir) check_eq("req_during_redirect", 64'(bus.mem_req_valid), 64'h0);
    if (bus.out_valid && ordy && !redir) begin
      if (exp_q.size() == 0) begin
        check_eq("out_when_none_expected", 64'(bus.out_valid), 64'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_pc", bus.out_pc, e.pc);
        check_eq("out_pc_plus4", bus.out_pc_plus4, e.pc + 64'd4);
        check_eq("out_instr", 64'(bus.out_instr), 64'(e.instr));
        if (want_first) begin
          check_eq("first_pc_after_restart", bus.out_pc, first_target);
          want_first = 1'b0;
        end
        if (first_out < 0) first_out = cyc;
        n_out++;
      end
    end
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      check_eq("req_addr", bus.mem_req_addr, exp_fetch);
      exp_q.push_back('{pc: exp_fetch, instr: mem_word(exp_fetch)});
      pend_q.push_back('{addr: exp_fetch, due: cyc + lat});
      exp_fetch = exp_fetch + 64'd4;
      if (first_req < 0) first_req = cyc;
      n_req++;
    end
    if (redir) begin
      exp_q.delete();
      exp_fetch    = {rpc[63:2], 2'b00};
      first_target = {rpc[63:2], 2'b00};
      want_first   = 1'b1;
    end
    prev_redir = redir;
    cyc++;
  endtask

  initial begin
    drive_idle();

    // 1: streaming with single-cycle memory.
    lat = 1;
    reset_dut();
    repeat (20) step(1'b0, 64'h0, 1'b1);
    check_eq("t1_first_out_latency", 64'(first_out - first_req), 64'd2);
    check_eq("t1_back_to_back", 64'(n_out), 64'(20 - first_req - 2));

    // 2: stall fills exactly DEPTH entries, then drains in order.
    reset_dut();
    repeat (10) step(1'b0, 64'h0, 1'b0);
    check_eq("t2_requests_while_stalled", 64'(n_req), 64'd4);
    check_eq("t2_req_valid_when_full", 64'(bus.mem_req_valid), 64'h0);
    check_eq("t2_no_output_while_stalled", 64'(n_out), 64'd0);
    repeat (12) step(1'b0, 64'h0, 1'b1);
    check_eq("t2_drained_past_full", 64'(n_out >= 5), 64'd1);

    // 3: redirect with two requests in flight on a 3-cycle memory.
    lat = 3;
    reset_dut();
    for (int i = 0; i < 10 && pend_q.size() < 2; i++) step(1'b0, 64'h0, 1'b1);
    check_eq("t3_two_outstanding", 64'(pend_q.size()), 64'd2);
    step(1'b1, 64'h100, 1'b1);
    repeat (15) step(1'b0, 64'h0, 1'b1);
    check_eq("t3_target_stream_seen", 64'(want_first), 64'h0);

    // 4: redirect coinciding with a pop and a response.
    lat = 1;
    reset_dut();
    repeat (6) step(1'b0, 64'h0, 1'b1);
    check_eq("t4_resp_due_at_redirect", 64'(pend_q.size() > 0 && pend_q[0].due == cyc), 64'd1);
    step(1'b1, 64'h400, 1'b1);
    repeat (10) step(1'b0, 64'h0, 1'b1);
    check_eq("t4_target_stream_seen", 64'(want_first), 64'h0);

    // 5: back-to-back redirects, second one misaligned.
    step(1'b1, 64'h200, 1'b1);
    step(1'b1, 64'h303, 1'b1);
    repeat (10) step(1'b0, 64'h0, 1'b1);
    check_eq("t5_target_stream_seen", 64'(want_first), 64'h0);

    // 6: asynchronous reset between clock edges.
    lat = 2;
    repeat (8) step(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_dut();
    repeat (10) step(1'b0, 64'h0, 1'b1);
    check_eq("t6_restart_seen", 64'(want_first), 64'h0);
    check_eq("t6_outputs_after_restart", 64'(n_out > 0), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
